// File: rtl/rf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared constants and types for the register-file write-port control slice
// (rf_wb_arbiter and its scoreboard).
//   XLEN             : register write data width
//   NREG             : number of architectural registers
//   IDX_W            : register index width
//   STARVE_LIMIT_DEF : default starvation threshold for the long-latency source
//   STARVE_W         : starvation counter width (threshold range 1..15)
//   reg_idx_t        : register index type
// -----------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int XLEN             = 32;
    localparam int NREG             = 32;
    localparam int IDX_W            = $clog2(NREG);
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage : rf_ctrl_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per architectural register, marking registers whose value is
// still owed by the long-latency unit. Register 0 never becomes busy.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   set_en, set_idx          : reserve a register at the next posedge
//   clr_en, clr_idx          : release a register at the next posedge
//   look{1,2,3}_idx / _busy  : combinational lookups (decode hazard check)
//   busy_vec                 : current busy bits (issue-side check)
//   busy_cnt                 : registered population count of busy bits
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_ctrl_pkg::*;
#(
    parameter int NREG = rf_ctrl_pkg::NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  reg_idx_t                 set_idx,
    input  logic                     clr_en,
    input  reg_idx_t                 clr_idx,
    input  reg_idx_t                 look1_idx,
    input  reg_idx_t                 look2_idx,
    input  reg_idx_t                 look3_idx,
    output logic                     look1_busy,
    output logic                     look2_busy,
    output logic                     look3_busy,
    output logic [NREG-1:0]          busy_vec,
    output logic [$clog2(NREG)-1:0]  busy_cnt
);

    localparam int CNT_W = $clog2(NREG);

    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // x0 is never reserved.
    assign busy_next[0] = 1'b0;

    // Set wins over clear for the same bit, but that cannot happen in
    // practice: a set needs the bit idle, a legal clear needs it busy.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_bit
            assign busy_next[gi] = (set_en && (set_idx == reg_idx_t'(gi)))
                                 || (busy_reg[gi] && !(clr_en && (clr_idx == reg_idx_t'(gi))));
        end
    endgenerate

    // Count is computed from the next-state so it lands in the same cycle
    // as the busy bits it describes.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign look1_busy = busy_reg[look1_idx];
    assign look2_busy = busy_reg[look2_idx];
    assign look3_busy = busy_reg[look3_idx];
    assign busy_vec   = busy_reg;
    assign busy_cnt   = cnt_reg;

endmodule : rf_scoreboard

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Owns the register-file write port and shares it between the in-order
// pipeline writeback (priority) and a long-latency result source. Tracks
// outstanding long-latency destinations for decode hazard stalls and asks
// the pipeline for bubbles when the long-latency source is starved.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_data         : pipeline writeback
//   pipe_hold                         : registered bubble request to pipeline
//   lat_valid/lat_rd/lat_data         : long-latency result (valid/ready)
//   lat_ready                         : long-latency result accepted
//   iss_valid/iss_rd, iss_ready       : long-latency issue reservation
//   dec_rs1/dec_rs2/dec_rd            : decode operands for hazard check
//   hazard_stall                      : decode must stall
//   rf_we/rf_rd/rf_wdata              : register file write port
//   busy_cnt                          : number of outstanding reservations
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int XLEN         = rf_ctrl_pkg::XLEN,
    parameter int NREG         = rf_ctrl_pkg::NREG,
    parameter int STARVE_LIMIT = rf_ctrl_pkg::STARVE_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_we,
    input  reg_idx_t                pipe_rd,
    input  logic [XLEN-1:0]         pipe_data,
    output logic                    pipe_hold,
    input  logic                    lat_valid,
    input  reg_idx_t                lat_rd,
    input  logic [XLEN-1:0]         lat_data,
    output logic                    lat_ready,
    input  logic                    iss_valid,
    input  reg_idx_t                iss_rd,
    output logic                    iss_ready,
    input  reg_idx_t                dec_rs1,
    input  reg_idx_t                dec_rs2,
    input  reg_idx_t                dec_rd,
    output logic                    hazard_stall,
    output logic                    rf_we,
    output reg_idx_t                rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [$clog2(NREG)-1:0] busy_cnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                rs1_busy;
    logic                rs2_busy;
    logic                rd_busy;
    logic [NREG-1:0]     busy_vec;
    logic                lat_hs;
    logic                iss_set;
    logic [STARVE_W-1:0] starve_reg;
    logic [STARVE_W-1:0] starve_next;
    logic                pipe_hold_reg;

    // ---------------- write-port arbitration (pipeline first) ----------------
    always_comb begin
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_wdata  = '0;
        lat_ready = 1'b0;
        if (!rst) begin
            if (pipe_we) begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_data;
            end else if (lat_valid) begin
                rf_we     = 1'b1;
                rf_rd     = lat_rd;
                rf_wdata  = lat_data;
                lat_ready = 1'b1;
            end
        end
    end

    assign lat_hs = lat_valid && lat_ready;

    // ---------------- scoreboard ----------------
    // Issue is checked against the registered busy bits only, so a register
    // being released this cycle still refuses a new reservation.
    assign iss_ready = !rst && !busy_vec[iss_rd];
    assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (iss_set),
        .set_idx    (iss_rd),
        .clr_en     (lat_hs),
        .clr_idx    (lat_rd),
        .look1_idx  (dec_rs1),
        .look2_idx  (dec_rs2),
        .look3_idx  (dec_rd),
        .look1_busy (rs1_busy),
        .look2_busy (rs2_busy),
        .look3_busy (rd_busy),
        .busy_vec   (busy_vec),
        .busy_cnt   (busy_cnt)
    );

    assign hazard_stall = !rst && (rs1_busy || rs2_busy || rd_busy);

    // ---------------- starvation tracking ----------------
    // Counts consecutive cycles a long-latency result waits; any cycle
    // without a waiting result (idle or accepted) restarts the count.
    always_comb begin
        starve_next = '0;
        if (lat_valid && !lat_ready) begin
            starve_next = (starve_reg == LIMIT) ? starve_reg : starve_reg + 1'b1;
        end
    end

    // Hold follows the saturated counter, so it drops at the same edge the
    // handshake resets the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg    <= '0;
            pipe_hold_reg <= 1'b0;
        end else begin
            starve_reg    <= starve_next;
            pipe_hold_reg <= (starve_next == LIMIT);
        end
    end

    assign pipe_hold = pipe_hold_reg;

    // A returned result must correspond to an outstanding reservation.
    a_lat_rd_reserved : assert property (
        @(posedge clk) disable iff (rst) lat_hs |-> busy_vec[lat_rd]
    );

endmodule : rf_wb_arbiter

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the core register file and shares it between two sources:
  - the in-order pipeline writeback;
  - a long-latency result source, e.g. a MUL/DIV unit or accelerator result return.
- Keeps a scoreboard of registers awaiting long-latency results and stalls decode on RAW/WAW hazards against them.
- Prevents starvation of the long-latency source by requesting a pipeline bubble.
- Sits between the writeback stage, the long-latency unit and the register file.

Parameters:
- XLEN, 32, data width of register write data.
- NREG, 32, number of architectural registers; index width is log2(NREG).
- STARVE_LIMIT, 4, consecutive blocked cycles of a pending long-latency result before pipe_hold asserts (range 1..15).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- pipe_we  in  1  pipeline writeback valid.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  XLEN  pipeline writeback data.
- pipe_hold  out  1  registered request: pipeline must present pipe_we=0 in every cycle after a cycle where this is 1.
- lat_valid  in  1  long-latency result valid.
- lat_rd  in  5  long-latency destination register.
- lat_data  in  XLEN  long-latency result data.
- lat_ready  out  1  long-latency result accepted this cycle.
- iss_valid  in  1  decode issues a long-latency op this cycle.
- iss_rd  in  5  destination of the issuing op.
- iss_ready  out  1  issue permitted (iss_rd not already pending).
- dec_rs1  in  5  decode source 1.
- dec_rs2  in  5  decode source 2.
- dec_rd  in  5  decode destination.
- hazard_stall  out  1  decode must stall.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write index.
- rf_wdata  out  XLEN  register file write data.
- busy_cnt  out  5  number of pending scoreboard entries.

Behaviour:
- Reset (rst=1 at posedge):
  - scoreboard cleared, starvation counter = 0, pipe_hold = 0.
  - Combinational outputs are forced during rst: rf_we=0, lat_ready=0, iss_ready=0, hazard_stall=0.
  - busy_cnt=0 from the next cycle.
  - Reset in mid-operation discards all pending reservations; no write is issued for them.
- Arbitration is combinational, 0-cycle latency:
  - The register file writes on the following negedge.
  - pipe_we=1: rf_we=1, rf_rd=pipe_rd, rf_wdata=pipe_data, lat_ready=0.
  - Else lat_valid=1: rf_we=1, rf_rd=lat_rd, rf_wdata=lat_data, lat_ready=1.
  - Else rf_we=0; rf_rd/rf_wdata are don't-care but driven 0.
  - A write to rd=0 is passed through; the register file drops it.
- Handshake: lat_valid holds lat_rd/lat_data stable until lat_ready=1. The transfer completes in the cycle where both are 1.
- Starvation counter:
  - Increments each cycle with lat_valid=1 and lat_ready=0.
  - Clears on a lat handshake or when lat_valid=0.
  - Saturates at STARVE_LIMIT.
  - pipe_hold is set at the posedge where the counter reaches STARVE_LIMIT, and clears at the posedge following the lat handshake.
- Scoreboard: busy bit per register 1..NREG-1; bit 0 is hardwired 0.
  - Set: iss_valid & iss_ready & iss_rd!=0, at posedge.
  - Clear: lat handshake, at posedge, bit lat_rd.
  - iss_ready = !busy[iss_rd]. Issue to a pending register is refused even if that register clears in the same cycle; retry the next cycle.
  - Set and clear of different registers in one cycle both take effect; busy_cnt changes by 0.
  - lat_valid with lat_rd not busy is a protocol error. It is still written; the scoreboard is unchanged; an assertion flags it in simulation.
- hazard_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]. No same-cycle forwarding: a register clearing this cycle still stalls this cycle.
- busy_cnt = popcount of busy bits, registered together with the scoreboard.

Decomposition:
- Package rf_ctrl_pkg: XLEN, NREG, reg_idx_t (5-bit index), STARVE_LIMIT default, starvation counter width.
- Sub-module rf_scoreboard: busy bit vector, set/clear ports, three lookup ports, popcount output.
- Arbitration mux and starvation logic stay in rf_wb_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with iss_valid=1, iss_rd=5 -> busy_cnt=0, rf_we=0, pipe_hold=0; after release busy[5]=0.
- Priority: pipe_we=1 rd=3 data=0xAAAA_0001 and lat_valid=1 rd=7 in the same cycle -> rf_rd=3, lat_ready=0. Next cycle pipe_we=0 -> rf_rd=7, rf_wdata=lat_data, lat_ready=1.
- Scoreboard and hazard:
  - Issue rd=9 -> busy_cnt=1.
  - dec_rs2=9 -> hazard_stall=1; dec_rs1=0, dec_rs2=0 -> hazard_stall=0.
  - Second issue rd=9 -> iss_ready=0.
  - lat handshake rd=9 -> busy_cnt=0 the next cycle; hazard_stall=0.
- Starvation: pipe_we=1 every cycle, lat_valid=1, STARVE_LIMIT=4 -> pipe_hold=1 after the 4th blocked cycle. Bench drops pipe_we -> lat handshake, and pipe_hold=0 the following cycle.
- Simultaneous events: issue rd=4 and lat clear rd=12 in the same cycle (12 busy) -> busy[4]=1, busy[12]=0, busy_cnt unchanged.
- x0: issue rd=0 -> busy_cnt stays 0, dec_rs1=0 never stalls.
